// File: rtl/parity_stream_checker.sv
// rtl/parity_stream_checker.sv - serial even/odd parity checker with saturating error statistics
//
// Receives frames of DATA_W data bits (LSB first) followed by one parity bit,
// qualified by bit_valid. Each frame is checked against even or odd parity,
// selected by odd_sel when the frame starts.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   begin a frame (sampled only while idle)
//   odd_sel    in   parity mode for the frame: 0 = even, 1 = odd
//   bit_valid  in   qualifier for bit_in
//   bit_in     in   serial data / parity bit
//   clr_cnt    in   synchronous clear of err_count and sticky_err
//   busy       out  frame in progress
//   done       out  one-cycle pulse when a frame completes
//   err        out  parity failure, meaningful only while done=1
//   data_out   out  last captured data word, held until the next done
//   err_count  out  saturating count of failed frames
//   sticky_err out  set by any failed frame until clr_cnt or reset

module parity_stream_checker #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              odd_sel,
    input  logic              bit_valid,
    input  logic              bit_in,
    input  logic              clr_cnt,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] data_out,
    output logic [CNT_W-1:0]  err_count,
    output logic              sticky_err
);

    localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_W - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY
    } state_t;

    state_t              state_q;
    logic [CW-1:0]       bitcnt_q;
    logic                acc_q;
    logic [DATA_W-1:0]   shreg_q;
    logic                busy_q;
    logic                done_q;
    logic                err_q;
    logic [DATA_W-1:0]   data_out_q;
    logic [CNT_W-1:0]    err_count_q;
    logic                sticky_q;

    logic                fail_d;
    logic                frame_end_d;
    logic [CNT_W-1:0]    err_count_d;

    // acc is preloaded with odd_sel, so a zero result means the frame is good
    // in either mode.
    assign fail_d      = acc_q ^ bit_in;
    assign frame_end_d = (state_q == S_PARITY) && bit_valid;
    assign err_count_d = (&err_count_q) ? err_count_q : err_count_q + CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            bitcnt_q    <= '0;
            acc_q       <= 1'b0;
            shreg_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            data_out_q  <= '0;
            err_count_q <= '0;
            sticky_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    // bit_valid is deliberately ignored here, including in the start cycle
                    if (start) begin
                        acc_q    <= odd_sel;
                        bitcnt_q <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (bit_valid) begin
                        shreg_q  <= {bit_in, shreg_q[DATA_W-1:1]};
                        acc_q    <= acc_q ^ bit_in;
                        bitcnt_q <= bitcnt_q + CW'(1);
                        if (bitcnt_q == LAST_BIT) begin
                            state_q <= S_PARITY;
                        end
                    end
                end
                S_PARITY: begin
                    if (bit_valid) begin
                        done_q     <= 1'b1;
                        err_q      <= fail_d;
                        data_out_q <= shreg_q;
                        busy_q     <= 1'b0;
                        state_q    <= S_IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase

            // A clear coinciding with a failing frame wins over the update.
            if (clr_cnt) begin
                err_count_q <= '0;
                sticky_q    <= 1'b0;
            end else if (frame_end_d && fail_d) begin
                err_count_q <= err_count_d;
                sticky_q    <= 1'b1;
            end
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign data_out   = data_out_q;
    assign err_count  = err_count_q;
    assign sticky_err = sticky_q;

endmodule

// File: tb/tb_parity_stream_checker.sv
// tb/tb_parity_stream_checker.sv - directed self-checking bench for parity_stream_checker

module tb_parity_stream_checker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       odd_sel = 1'b0;
    logic       bit_valid = 1'b0;
    logic       bit_in = 1'b0;
    logic       clr_cnt = 1'b0;

    logic       busy, done, err, sticky_err;
    logic [7:0] data_out, err_count;

    logic       busy2, done2, err2, sticky_err2;
    logic [7:0] data_out2;
    logic [1:0] err_count2;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    parity_stream_checker #(.DATA_W(8), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .odd_sel(odd_sel),
        .bit_valid(bit_valid), .bit_in(bit_in), .clr_cnt(clr_cnt),
        .busy(busy), .done(done), .err(err), .data_out(data_out),
        .err_count(err_count), .sticky_err(sticky_err)
    );

    parity_stream_checker #(.DATA_W(8), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .odd_sel(odd_sel),
        .bit_valid(bit_valid), .bit_in(bit_in), .clr_cnt(clr_cnt),
        .busy(busy2), .done(done2), .err(err2), .data_out(data_out2),
        .err_count(err_count2), .sticky_err(sticky_err2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one complete frame. Returns the outputs seen just after the
    // edge that samples the parity bit, the number of cycles from start to
    // that point, and how many cycles showed done before it.
    task automatic send_frame(input logic [7:0] data, input logic par, input logic odd,
                              input bit gaps, input bit mid_start, input bit clr_par,
                              output logic o_done, output logic o_err,
                              output logic [7:0] o_data, output int o_cycles,
                              output int o_early);
        int n;
        int early;
        n = 0;
        early = 0;
        start = 1'b1;
        odd_sel = odd;
        tick(); n++;
        start = 1'b0;
        odd_sel = ~odd;
        for (int i = 0; i < 8; i++) begin
            if (gaps) begin
                int g;
                g = $urandom_range(0, 5);
                for (int k = 0; k < g; k++) begin
                    bit_valid = 1'b0;
                    bit_in = ~data[i];
                    start = mid_start;
                    if (done) early++;
                    tick(); n++;
                end
            end
            bit_valid = 1'b1;
            bit_in = data[i];
            start = mid_start;
            if (done) early++;
            tick(); n++;
        end
        bit_valid = 1'b1;
        bit_in = par;
        start = 1'b0;
        clr_cnt = clr_par;
        if (done) early++;
        tick(); n++;
        bit_valid = 1'b0;
        bit_in = 1'b0;
        clr_cnt = 1'b0;
        o_done = done;
        o_err = err;
        o_data = data_out;
        o_cycles = n;
        o_early = early;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        n_checks++;
        if ({busy, done, err, data_out, err_count, sticky_err} !== 20'h0) begin
            n_fail++;
            $display("FAIL reset_state: got busy=%b done=%b err=%b data=%h cnt=%h sticky=%b, want all 0",
                     busy, done, err, data_out, err_count, sticky_err);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_even_pass();
        logic d, e;
        logic [7:0] q;
        int cyc, early;
        start = 1'b1; odd_sel = 1'b0;
        tick();
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++; $display("FAIL busy_after_start: got %b want 1", busy);
        end
        // Finish this frame through the helper sequence by restarting cleanly.
        rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
        send_frame(8'hA5, 1'b0, 1'b0, 0, 0, 0, d, e, q, cyc, early);
        n_checks++;
        if (d !== 1'b1 || e !== 1'b0 || q !== 8'hA5 || early !== 0) begin
            n_fail++;
            $display("FAIL even_a5: got done=%b err=%b data=%h early=%0d want 1 0 a5 0", d, e, q, early);
        end
        n_checks++;
        if (cyc !== 10) begin
            n_fail++; $display("FAIL even_latency: got %0d cycles want 10", cyc);
        end
        n_checks++;
        if (busy !== 1'b0 || err_count !== 8'd0 || sticky_err !== 1'b0) begin
            n_fail++;
            $display("FAIL even_stats: got busy=%b cnt=%0d sticky=%b want 0 0 0", busy, err_count, sticky_err);
        end
        tick();
        n_checks++;
        if (done !== 1'b0 || err !== 1'b0 || data_out !== 8'hA5) begin
            n_fail++;
            $display("FAIL done_pulse: got done=%b err=%b data=%h want 0 0 a5", done, err, data_out);
        end
    endtask

    task automatic test_errors();
        logic d, e;
        logic [7:0] q;
        int cyc, early;
        send_frame(8'hA5, 1'b1, 1'b0, 0, 0, 0, d, e, q, cyc, early);
        n_checks++;
        if (d !== 1'b1 || e !== 1'b1 || err_count !== 8'd1 || sticky_err !== 1'b1) begin
            n_fail++;
            $display("FAIL even_bad_parity: got done=%b err=%b cnt=%0d sticky=%b want 1 1 1 1", d, e, err_count, sticky_err);
        end
        tick();
        send_frame(8'h01, 1'b0, 1'b1, 0, 0, 0, d, e, q, cyc, early);
        n_checks++;
        if (d !== 1'b1 || e !== 1'b0 || q !== 8'h01 || err_count !== 8'd1) begin
            n_fail++;
            $display("FAIL odd_good: got done=%b err=%b data=%h cnt=%0d want 1 0 01 1", d, e, q, err_count);
        end
        tick();
        send_frame(8'h01, 1'b1, 1'b1, 0, 0, 0, d, e, q, cyc, early);
        n_checks++;
        if (d !== 1'b1 || e !== 1'b1 || err_count !== 8'd2 || sticky_err !== 1'b1) begin
            n_fail++;
            $display("FAIL odd_bad: got done=%b err=%b cnt=%0d sticky=%b want 1 1 2 1", d, e, err_count, sticky_err);
        end
        tick();
    endtask

    task automatic test_gaps();
        logic d, e;
        logic [7:0] q;
        int cyc, early;
        send_frame(8'h3C, 1'b0, 1'b0, 1, 1, 0, d, e, q, cyc, early);
        n_checks++;
        if (d !== 1'b1 || e !== 1'b0 || q !== 8'h3C || early !== 0) begin
            n_fail++;
            $display("FAIL gaps_3c: got done=%b err=%b data=%h early=%0d want 1 0 3c 0", d, e, q, early);
        end
        n_checks++;
        if (err_count !== 8'd2) begin
            n_fail++; $display("FAIL gaps_count: got %0d want 2", err_count);
        end
        tick();
    endtask

    task automatic test_midframe_reset();
        logic d, e;
        logic [7:0] q;
        int cyc, early;
        int seen;
        start = 1'b1; odd_sel = 1'b0;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bit_valid = 1'b1; bit_in = 1'b1;
            tick();
        end
        bit_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, err, data_out, err_count, sticky_err} !== 20'h0) begin
            n_fail++;
            $display("FAIL midframe_reset: got busy=%b done=%b err=%b data=%h cnt=%h sticky=%b want all 0",
                     busy, done, err, data_out, err_count, sticky_err);
        end
        tick();
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            bit_valid = 1'b1; bit_in = i[0];
            tick();
            if (done || busy) seen++;
        end
        bit_valid = 1'b0;
        n_checks++;
        if (seen !== 0) begin
            n_fail++; $display("FAIL no_done_after_reset: got %0d active cycles want 0", seen);
        end
        send_frame(8'hFF, 1'b0, 1'b0, 0, 0, 0, d, e, q, cyc, early);
        n_checks++;
        if (d !== 1'b1 || e !== 1'b0 || q !== 8'hFF) begin
            n_fail++;
            $display("FAIL after_reset_ff: got done=%b err=%b data=%h want 1 0 ff", d, e, q);
        end
        tick();
    endtask

    task automatic test_saturation();
        logic d, e;
        logic [7:0] q;
        int cyc, early;
        logic [1:0] exp_cnt [5];
        exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        for (int f = 0; f < 5; f++) begin
            send_frame(8'hA5, 1'b1, 1'b0, 0, 0, 0, d, e, q, cyc, early);
            n_checks++;
            if (done2 !== 1'b1 || err2 !== 1'b1 || err_count2 !== exp_cnt[f] || sticky_err2 !== 1'b1) begin
                n_fail++;
                $display("FAIL sat_frame%0d: got done=%b err=%b cnt=%0d sticky=%b want 1 1 %0d 1",
                         f, done2, err2, err_count2, sticky_err2, exp_cnt[f]);
            end
        end
        send_frame(8'hA5, 1'b1, 1'b0, 0, 0, 1, d, e, q, cyc, early);
        n_checks++;
        if (done2 !== 1'b1 || err2 !== 1'b1 || err_count2 !== 2'd0 || sticky_err2 !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_wins: got done=%b err=%b cnt=%0d sticky=%b want 1 1 0 0",
                     done2, err2, err_count2, sticky_err2);
        end
        n_checks++;
        if (err_count !== 8'd0 || sticky_err !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_wins_wide: got cnt=%0d sticky=%b want 0 0", err_count, sticky_err);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic d, e;
        logic [7:0] q;
        int cyc, early;
        logic [7:0] frames [4];
        realtime t_prev, t_now;
        frames = '{8'h12, 8'hF0, 8'h81, 8'h7E};
        t_prev = 0;
        for (int f = 0; f < 4; f++) begin
            // Parity chosen so every frame passes in even mode.
            send_frame(frames[f], ^frames[f], 1'b0, 0, 0, 0, d, e, q, cyc, early);
            t_now = $realtime;
            n_checks++;
            if (d !== 1'b1 || e !== 1'b0 || q !== frames[f] || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_frame%0d: got done=%b err=%b data=%h busy=%b want 1 0 %h 0",
                         f, d, e, q, busy, frames[f]);
            end
            if (f > 0) begin
                n_checks++;
                if (t_now - t_prev != 100.0) begin
                    n_fail++;
                    $display("FAIL b2b_period%0d: got %0t want 100 time units", f, t_now - t_prev);
                end
            end
            t_prev = t_now;
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_even_pass();
        test_errors();
        test_gaps();
        test_midframe_reset();
        test_saturation();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout want finish");
        $fatal(1);
    end

endmodule
